// File: rtl/vga_timing_gen_pkg.sv
// vga_pkg: shared timing constants and coordinate type for the VGA timing
// generator. Default values describe 640x480@60 with a 25.175 MHz pixel clock.
// Ports: none (package).
package vga_pkg;

  typedef logic [9:0] coord_t;

  localparam int H_VISIBLE   = 640;
  localparam int H_FP        = 16;
  localparam int H_SYNC      = 96;
  localparam int H_BP        = 48;
  localparam int V_VISIBLE   = 480;
  localparam int V_FP        = 10;
  localparam int V_SYNC      = 2;
  localparam int V_BP        = 33;

  localparam int ANIM_DIV    = 8;
  localparam int ANIM_FRAMES = 4;

  localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Sync windows are half-open: START is the first active column/line,
  // END is the first inactive one.
  localparam int HS_START = H_VISIBLE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: bundle of scan outputs from the timing generator to the
// draw stages.
//   DrawX/DrawY   scan coordinates
//   blank         1 = visible pixel
//   hs/vs         active-low syncs
//   vblank_start  one-cycle pulse on entry to vertical blanking
//   anim_tick     one-cycle pulse every ANIM_DIV frames
//   anim_frame    sprite animation frame index
// master = timing generator, slave = consumers.
interface vga_timing_gen_if
  import vga_pkg::*;
#(
  parameter int ANIM_FRAMES = vga_pkg::ANIM_FRAMES
);

  localparam int FW = $clog2(ANIM_FRAMES);

  coord_t          DrawX;
  coord_t          DrawY;
  logic            blank;
  logic            hs;
  logic            vs;
  logic            vblank_start;
  logic            anim_tick;
  logic [FW-1:0]   anim_frame;

  modport master (
    output DrawX, DrawY, blank, hs, vs, vblank_start, anim_tick, anim_frame
  );

  modport slave (
    input DrawX, DrawY, blank, hs, vs, vblank_start, anim_tick, anim_frame
  );

endinterface

// File: rtl/vga_timing_gen_anim_divider.sv
// anim_divider: counts vertical-blank events and advances the sprite
// animation frame every ANIM_DIV of them.
// Ports:
//   vga_clk      pixel clock
//   reset_n      asynchronous active-low reset
//   vblank_next  vblank_start as it will be registered on this edge
//   anim_tick    registered pulse, coincident with the registered vblank_start
//   anim_frame   animation frame index, wraps at ANIM_FRAMES
module anim_divider #(
  parameter int ANIM_DIV    = 8,
  parameter int ANIM_FRAMES = 4
) (
  input  logic                           vga_clk,
  input  logic                           reset_n,
  input  logic                           vblank_next,
  output logic                           anim_tick,
  output logic [$clog2(ANIM_FRAMES)-1:0] anim_frame
);

  localparam int FW = $clog2(ANIM_FRAMES);
  localparam logic [7:0] DIV_LAST = 8'(ANIM_DIV - 1);

  logic [7:0] div_count;

  // The input is the next-state vblank pulse, so the tick and the frame
  // update land in the same cycle the top presents vblank_start.
  // ANIM_FRAMES is a power of two, so the frame index wraps by overflow.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      div_count  <= '0;
      anim_tick  <= 1'b0;
      anim_frame <= '0;
    end else begin
      anim_tick <= 1'b0;
      if (vblank_next) begin
        if (div_count == DIV_LAST) begin
          div_count  <= '0;
          anim_tick  <= 1'b1;
          anim_frame <= anim_frame + FW'(1);
        end else begin
          div_count <= div_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-timing generator for the sprite/palette draw pipeline.
// Ports:
//   vga_clk  pixel clock, all logic on the rising edge
//   reset_n  asynchronous active-low reset
//   vga      master side of vga_timing_gen_if (DrawX, DrawY, blank, hs, vs,
//            vblank_start, anim_tick, anim_frame)
// Every output is a register loaded from the next-state counters, so the
// flags always describe the DrawX/DrawY shown in the same cycle.
module vga_timing_gen
  import vga_pkg::coord_t;
#(
  parameter int H_VISIBLE   = vga_pkg::H_VISIBLE,
  parameter int H_FP        = vga_pkg::H_FP,
  parameter int H_SYNC      = vga_pkg::H_SYNC,
  parameter int H_BP        = vga_pkg::H_BP,
  parameter int V_VISIBLE   = vga_pkg::V_VISIBLE,
  parameter int V_FP        = vga_pkg::V_FP,
  parameter int V_SYNC      = vga_pkg::V_SYNC,
  parameter int V_BP        = vga_pkg::V_BP,
  parameter int ANIM_DIV    = vga_pkg::ANIM_DIV,
  parameter int ANIM_FRAMES = vga_pkg::ANIM_FRAMES
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  vga_timing_gen_if.master  vga
);

  localparam int FW = $clog2(ANIM_FRAMES);

  localparam coord_t H_LAST   = coord_t'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t V_LAST   = coord_t'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t H_VIS_C  = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_C  = coord_t'(V_VISIBLE);
  localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC);

  coord_t        draw_x;
  coord_t        draw_y;
  logic          blank_r;
  logic          hs_r;
  logic          vs_r;
  logic          vbs_r;
  logic          anim_tick;
  logic [FW-1:0] anim_frame;

  coord_t        x_next;
  coord_t        y_next;
  logic          blank_next;
  logic          hs_next;
  logic          vs_next;
  logic          vbs_next;

  // Next-state counters and the flags derived from them. Because vs is a
  // function of the next line only, it changes on the edge that brings
  // DrawX back to 0.
  always_comb begin
    x_next = draw_x + coord_t'(1);
    y_next = draw_y;
    if (draw_x == H_LAST) begin
      x_next = '0;
      y_next = (draw_y == V_LAST) ? '0 : draw_y + coord_t'(1);
    end
    blank_next = (x_next < H_VIS_C) && (y_next < V_VIS_C);
    hs_next    = !((x_next >= HS_START) && (x_next < HS_END));
    vs_next    = !((y_next >= VS_START) && (y_next < VS_END));
    vbs_next   = (x_next == '0) && (y_next == V_VIS_C);
  end

  // Reset parks the scan at (0,0) with blank forced low; the first edge after
  // release moves to (1,0), so the (0,0) pixel of that frame stays blanked.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      draw_x  <= '0;
      draw_y  <= '0;
      blank_r <= 1'b0;
      hs_r    <= 1'b1;
      vs_r    <= 1'b1;
      vbs_r   <= 1'b0;
    end else begin
      draw_x  <= x_next;
      draw_y  <= y_next;
      blank_r <= blank_next;
      hs_r    <= hs_next;
      vs_r    <= vs_next;
      vbs_r   <= vbs_next;
    end
  end

  anim_divider #(
    .ANIM_DIV    (ANIM_DIV),
    .ANIM_FRAMES (ANIM_FRAMES)
  ) u_anim_divider (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .vblank_next (vbs_next),
    .anim_tick   (anim_tick),
    .anim_frame  (anim_frame)
  );

  assign vga.DrawX        = draw_x;
  assign vga.DrawY        = draw_y;
  assign vga.blank        = blank_r;
  assign vga.hs           = hs_r;
  assign vga.vs           = vs_r;
  assign vga.vblank_start = vbs_r;
  assign vga.anim_tick    = anim_tick;
  assign vga.anim_frame   = anim_frame;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen.
// dut0 uses the default 640x480 timing for line-level behaviour, dut1 uses a
// tiny 25x19 raster so whole frames, animation and mid-frame reset fit in a
// short run, and dut2 uses H_VISIBLE=320 (H_TOTAL=480).
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.ANIM_FRAMES(4)) vif0 ();
  vga_timing_gen_if #(.ANIM_FRAMES(4)) vif1 ();
  vga_timing_gen_if #(.ANIM_FRAMES(4)) vif2 ();

  vga_timing_gen dut0 (
    .vga_clk (clk),
    .reset_n (rst_n),
    .vga     (vif0)
  );

  // Small raster: H 16+2+4+3=25 (hs low 18..21), V 12+2+2+3=19 (vs low 14..15)
  vga_timing_gen #(
    .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_VISIBLE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .ANIM_DIV(8), .ANIM_FRAMES(4)
  ) dut1 (
    .vga_clk (clk),
    .reset_n (rst_n),
    .vga     (vif1)
  );

  vga_timing_gen #(.H_VISIBLE(320)) dut2 (
    .vga_clk (clk),
    .reset_n (rst_n),
    .vga     (vif2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves reset released just after an edge, all DUTs parked at (0,0).
  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++; if (vif0.DrawX !== 10'd0) begin errors++; $display("FAIL rst_DrawX got %0d want 0", vif0.DrawX); end
    checks++; if (vif0.DrawY !== 10'd0) begin errors++; $display("FAIL rst_DrawY got %0d want 0", vif0.DrawY); end
    checks++; if (vif0.blank !== 1'b0) begin errors++; $display("FAIL rst_blank got %b want 0", vif0.blank); end
    checks++; if (vif0.hs !== 1'b1) begin errors++; $display("FAIL rst_hs got %b want 1", vif0.hs); end
    checks++; if (vif0.vs !== 1'b1) begin errors++; $display("FAIL rst_vs got %b want 1", vif0.vs); end
    checks++; if (vif0.vblank_start !== 1'b0) begin errors++; $display("FAIL rst_vbs got %b want 0", vif0.vblank_start); end
    checks++; if (vif0.anim_tick !== 1'b0) begin errors++; $display("FAIL rst_tick got %b want 0", vif0.anim_tick); end
    checks++; if (vif0.anim_frame !== 2'd0) begin errors++; $display("FAIL rst_frame got %0d want 0", vif0.anim_frame); end
    rst_n = 1'b1;
  endtask

  // Default timing, 800 edges from reset release: one full line plus wrap.
  task automatic test_line0();
    int   x, y, hs_low, first_low;
    logic eb, ehs;
    apply_reset();
    hs_low = 0;
    first_low = -1;
    for (int k = 1; k <= 800; k++) begin
      step();
      x = k % 800;
      y = k / 800;
      eb  = (x < 640) && (y < 480);
      ehs = !((x >= 656) && (x < 752));
      checks++; if (vif0.DrawX !== 10'(x)) begin errors++; $display("FAIL line0_DrawX k=%0d got %0d want %0d", k, vif0.DrawX, x); end
      checks++; if (vif0.DrawY !== 10'(y)) begin errors++; $display("FAIL line0_DrawY k=%0d got %0d want %0d", k, vif0.DrawY, y); end
      checks++; if (vif0.blank !== eb) begin errors++; $display("FAIL line0_blank x=%0d got %b want %b", x, vif0.blank, eb); end
      checks++; if (vif0.hs !== ehs) begin errors++; $display("FAIL line0_hs x=%0d got %b want %b", x, vif0.hs, ehs); end
      checks++; if (vif0.vs !== 1'b1) begin errors++; $display("FAIL line0_vs x=%0d got %b want 1", x, vif0.vs); end
      if (vif0.hs === 1'b0) begin
        hs_low++;
        if (first_low < 0) first_low = x;
      end
    end
    checks++; if (hs_low != 96) begin errors++; $display("FAIL line0_hs_width got %0d want 96", hs_low); end
    checks++; if (first_low != 656) begin errors++; $display("FAIL line0_hs_first got %0d want 656", first_low); end
  endtask

  // Small raster, one full frame of 475 edges.
  task automatic test_frame();
    int   x, y, vs_low, vbs_cnt;
    logic eb, ehs, evs, evbs;
    apply_reset();
    vs_low = 0;
    vbs_cnt = 0;
    for (int k = 1; k <= 475; k++) begin
      step();
      x = k % 25;
      y = (k / 25) % 19;
      eb   = (x < 16) && (y < 12);
      ehs  = !((x >= 18) && (x < 22));
      evs  = !((y >= 14) && (y < 16));
      evbs = (x == 0) && (y == 12);
      checks++; if (vif1.DrawX !== 10'(x)) begin errors++; $display("FAIL frame_DrawX k=%0d got %0d want %0d", k, vif1.DrawX, x); end
      checks++; if (vif1.DrawY !== 10'(y)) begin errors++; $display("FAIL frame_DrawY k=%0d got %0d want %0d", k, vif1.DrawY, y); end
      checks++; if (vif1.blank !== eb) begin errors++; $display("FAIL frame_blank (%0d,%0d) got %b want %b", x, y, vif1.blank, eb); end
      checks++; if (vif1.hs !== ehs) begin errors++; $display("FAIL frame_hs (%0d,%0d) got %b want %b", x, y, vif1.hs, ehs); end
      checks++; if (vif1.vs !== evs) begin errors++; $display("FAIL frame_vs (%0d,%0d) got %b want %b", x, y, vif1.vs, evs); end
      checks++; if (vif1.vblank_start !== evbs) begin errors++; $display("FAIL frame_vbs (%0d,%0d) got %b want %b", x, y, vif1.vblank_start, evbs); end
      if (vif1.vs === 1'b0) vs_low++;
      if (vif1.vblank_start === 1'b1) vbs_cnt++;
    end
    checks++; if (vs_low != 50) begin errors++; $display("FAIL frame_vs_width got %0d want 50", vs_low); end
    checks++; if (vbs_cnt != 1) begin errors++; $display("FAIL frame_vbs_count got %0d want 1", vbs_cnt); end
  endtask

  // Small raster, 32 frames: tick every 8th vblank, frame index 0..3 and back.
  task automatic test_anim();
    int   x, y, nvb, eframe, ticks;
    logic evbs, etick;
    apply_reset();
    nvb = 0;
    ticks = 0;
    for (int k = 1; k <= 32 * 475; k++) begin
      step();
      x = k % 25;
      y = (k / 25) % 19;
      evbs = (x == 0) && (y == 12);
      if (evbs) nvb++;
      etick  = evbs && (nvb % 8 == 0);
      eframe = (nvb / 8) % 4;
      checks++; if (vif1.anim_tick !== etick) begin errors++; $display("FAIL anim_tick k=%0d got %b want %b", k, vif1.anim_tick, etick); end
      checks++; if (vif1.anim_frame !== 2'(eframe)) begin errors++; $display("FAIL anim_frame k=%0d got %0d want %0d", k, vif1.anim_frame, eframe); end
      if (vif1.anim_tick === 1'b1) ticks++;
    end
    checks++; if (ticks != 4) begin errors++; $display("FAIL anim_tick_count got %0d want 4", ticks); end
    checks++; if (vif1.anim_frame !== 2'd0) begin errors++; $display("FAIL anim_wrap got %0d want 0", vif1.anim_frame); end
  endtask

  // Small raster: reset asserted at (10,8) of frame 9 with anim_frame=1.
  task automatic test_reset_mid();
    int cnt;
    apply_reset();
    repeat (8 * 475 + 210) step();
    checks++; if (vif1.DrawX !== 10'd10) begin errors++; $display("FAIL mid_pre_DrawX got %0d want 10", vif1.DrawX); end
    checks++; if (vif1.DrawY !== 10'd8) begin errors++; $display("FAIL mid_pre_DrawY got %0d want 8", vif1.DrawY); end
    checks++; if (vif1.anim_frame !== 2'd1) begin errors++; $display("FAIL mid_pre_frame got %0d want 1", vif1.anim_frame); end
    rst_n = 1'b0;
    #1;
    checks++; if (vif1.DrawX !== 10'd0) begin errors++; $display("FAIL mid_DrawX got %0d want 0", vif1.DrawX); end
    checks++; if (vif1.DrawY !== 10'd0) begin errors++; $display("FAIL mid_DrawY got %0d want 0", vif1.DrawY); end
    checks++; if (vif1.blank !== 1'b0) begin errors++; $display("FAIL mid_blank got %b want 0", vif1.blank); end
    checks++; if (vif1.anim_frame !== 2'd0) begin errors++; $display("FAIL mid_frame got %0d want 0", vif1.anim_frame); end
    repeat (3) step();
    rst_n = 1'b1;
    step();
    checks++; if (vif1.DrawX !== 10'd1) begin errors++; $display("FAIL mid_post1_DrawX got %0d want 1", vif1.DrawX); end
    checks++; if (vif1.DrawY !== 10'd0) begin errors++; $display("FAIL mid_post1_DrawY got %0d want 0", vif1.DrawY); end
    step();
    checks++; if (vif1.DrawX !== 10'd2) begin errors++; $display("FAIL mid_post2_DrawX got %0d want 2", vif1.DrawX); end
    cnt = 2;
    while (vif1.vblank_start !== 1'b1 && cnt < 1000) begin
      step();
      cnt++;
    end
    checks++; if (cnt != 300) begin errors++; $display("FAIL mid_vbs_delay got %0d want 300", cnt); end
  endtask

  // H_VISIBLE=320: hs low 336..431, line wraps after DrawX=479.
  task automatic test_cross();
    int   x, y, hs_low, max_x;
    logic eb, ehs;
    apply_reset();
    hs_low = 0;
    max_x = 0;
    for (int k = 1; k <= 480; k++) begin
      step();
      x = k % 480;
      y = k / 480;
      eb  = (x < 320) && (y < 480);
      ehs = !((x >= 336) && (x < 432));
      checks++; if (vif2.DrawX !== 10'(x)) begin errors++; $display("FAIL cross_DrawX k=%0d got %0d want %0d", k, vif2.DrawX, x); end
      checks++; if (vif2.DrawY !== 10'(y)) begin errors++; $display("FAIL cross_DrawY k=%0d got %0d want %0d", k, vif2.DrawY, y); end
      checks++; if (vif2.hs !== ehs) begin errors++; $display("FAIL cross_hs x=%0d got %b want %b", x, vif2.hs, ehs); end
      checks++; if (vif2.blank !== eb) begin errors++; $display("FAIL cross_blank x=%0d got %b want %b", x, vif2.blank, eb); end
      if (vif2.hs === 1'b0) hs_low++;
      if (int'(vif2.DrawX) > max_x) max_x = int'(vif2.DrawX);
    end
    checks++; if (hs_low != 96) begin errors++; $display("FAIL cross_hs_width got %0d want 96", hs_low); end
    checks++; if (max_x != 479) begin errors++; $display("FAIL cross_max_x got %0d want 479", max_x); end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_line0();
    test_frame();
    test_anim();
    test_reset_mid();
    test_cross();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
